// File: rtl/piso_tx_shifter_if.sv
// Handshake and serial-line bundle between a parallel producer and piso_tx_shifter.
// A word transfers on a clk edge where load && ready; ready drops for the whole frame.
interface piso_tx_shifter_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             load;
    logic             shift_en;
    logic             abort;
    logic             ready;
    logic             sout;
    logic             sout_valid;
    logic             frame_start;
    logic             done;

    modport master (
        output din, load, shift_en, abort,
        input  ready, sout, sout_valid, frame_start, done
    );

    modport slave (
        input  din, load, shift_en, abort,
        output ready, sout, sout_valid, frame_start, done
    );
endinterface

// File: rtl/piso_tx_shifter.sv
// Parallel-in, serial-out transmit shifter: takes a word on load/ready, emits one bit
// per shift_en tick on a registered serial line with frame start/done pulses.
module piso_tx_shifter #(
    parameter int WIDTH      = 8,
    parameter bit LSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    piso_tx_shifter_if.slave bus,
    output logic             dbg_state
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    generate
        if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
            $error("piso_tx_shifter: WIDTH must be in 2..32");
        end
    endgenerate

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] shifted;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ready_d;
    logic             sout_d;
    logic             sout_valid_d;
    logic             frame_start_d;
    logic             done_d;

    always_comb begin
        shifted       = LSB_FIRST ? (shreg_q >> 1) : (shreg_q << 1);
        state_d       = state_q;
        shreg_d       = shreg_q;
        cnt_d         = cnt_q;
        frame_start_d = 1'b0;
        done_d        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // abort wins over load, so a cancelled request never starts a frame
                if (!bus.abort && bus.load) begin
                    state_d       = ST_SHIFT;
                    shreg_d       = bus.din;
                    cnt_d         = '0;
                    frame_start_d = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (bus.shift_en) begin
                    shreg_d = shifted;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        // Outputs are precomputed from the next state so every port comes straight off a flop.
        ready_d      = (state_d == ST_IDLE);
        sout_valid_d = (state_d == ST_SHIFT);
        if (state_d == ST_SHIFT) begin
            sout_d = LSB_FIRST ? shreg_d[0] : shreg_d[WIDTH-1];
        end else begin
            sout_d = IDLE_LEVEL;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= ST_IDLE;
            shreg_q         <= '0;
            cnt_q           <= '0;
            bus.ready       <= 1'b1;
            bus.sout        <= IDLE_LEVEL;
            bus.sout_valid  <= 1'b0;
            bus.frame_start <= 1'b0;
            bus.done        <= 1'b0;
        end else begin
            state_q         <= state_d;
            shreg_q         <= shreg_d;
            cnt_q           <= cnt_d;
            bus.ready       <= ready_d;
            bus.sout        <= sout_d;
            bus.sout_valid  <= sout_valid_d;
            bus.frame_start <= frame_start_d;
            bus.done        <= done_d;
        end
    end

    assign dbg_state = (state_q == ST_SHIFT);
endmodule

// File: tb/tb_piso_tx_shifter.sv
// Bench for piso_tx_shifter: an LSB-first and an MSB-first instance share one stimulus;
// expected serial bits are queued when a word is loaded and popped as the line emits them.
module tb_piso_tx_shifter;
    localparam int W = 8;

    logic         clk      = 1'b0;
    logic         clk_en   = 1'b0;
    logic         rst      = 1'b1;
    logic [W-1:0] din      = '0;
    logic         load     = 1'b0;
    logic         shift_en = 1'b0;
    logic         abort    = 1'b0;
    logic         use_msb  = 1'b0;
    logic         dbg_a, dbg_b;

    int           n_tests = 0;
    int           n_fail  = 0;
    logic [0:0]   exp_q[$];

    piso_tx_shifter_if #(.WIDTH(W)) a_if ();
    piso_tx_shifter_if #(.WIDTH(W)) b_if ();

    assign a_if.din      = din;
    assign a_if.load     = load;
    assign a_if.shift_en = shift_en;
    assign a_if.abort    = abort;
    assign b_if.din      = din;
    assign b_if.load     = load;
    assign b_if.shift_en = shift_en;
    assign b_if.abort    = abort;

    piso_tx_shifter #(.WIDTH(W), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) dut_lsb (
        .clk       (clk),
        .rst       (rst),
        .bus       (a_if),
        .dbg_state (dbg_a)
    );

    piso_tx_shifter #(.WIDTH(W), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) dut_msb (
        .clk       (clk),
        .rst       (rst),
        .bus       (b_if),
        .dbg_state (dbg_b)
    );

    logic o_ready, o_sout, o_valid, o_fs, o_done, o_state;
    assign o_ready = use_msb ? b_if.ready       : a_if.ready;
    assign o_sout  = use_msb ? b_if.sout        : a_if.sout;
    assign o_valid = use_msb ? b_if.sout_valid  : a_if.sout_valid;
    assign o_fs    = use_msb ? b_if.frame_start : a_if.frame_start;
    assign o_done  = use_msb ? b_if.done        : a_if.done;
    assign o_state = use_msb ? dbg_b            : dbg_a;

    // clock / reset
    always #5 if (clk_en) clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_idle(input string tag, input logic done_exp);
        check({tag, "_ready"}, 32'(o_ready), 32'd1);
        check({tag, "_sout"},  32'(o_sout),  32'd1);
        check({tag, "_valid"}, 32'(o_valid), 32'd0);
        check({tag, "_fs"},    32'(o_fs),    32'd0);
        check({tag, "_done"},  32'(o_done),  32'(done_exp));
        check({tag, "_state"}, 32'(o_state), 32'd0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Load word d, hold each bit for per cycles; optionally pulse a busy load,
    // abort, or reset during bit busy_k / abort_k / rst_k (-1 = never).
    task automatic run_frame(input logic [W-1:0] d, input int per,
                             input int busy_k, input int abort_k, input int rst_k);
        check("rdy_pre", 32'(o_ready), 32'd1);
        for (int k = 0; k < W; k++) begin
            exp_q.push_back(use_msb ? d[W-1-k] : d[k]);
        end
        din      = d;
        load     = 1'b1;
        abort    = 1'b0;
        shift_en = 1'b1;
        step();
        load = 1'b0;
        din  = W'($urandom_range(0, 255));
        for (int k = 0; k < W; k++) begin
            for (int j = 0; j < per; j++) begin
                check("sout",   32'(o_sout),  32'(exp_q[0]));
                check("valid",  32'(o_valid), 32'd1);
                check("ready",  32'(o_ready), 32'd0);
                check("fstart", 32'(o_fs),    32'(k == 0 && j == 0));
                check("done",   32'(o_done),  32'd0);
                check("state",  32'(o_state), 32'd1);
                if (k == rst_k && j == 0) begin
                    #2 rst = 1'b0;
                    #1 check_idle("rst_async", 1'b0);
                    @(posedge clk);
                    #1 check_idle("rst_hold", 1'b0);
                    rst      = 1'b1;
                    shift_en = 1'b0;
                    step();
                    check_idle("rst_rel", 1'b0);
                    exp_q.delete();
                    return;
                end
                if (k == abort_k && j == 0) begin
                    abort = 1'b1;
                    step();
                    abort = 1'b0;
                    check_idle("abort", 1'b0);
                    step();
                    check_idle("abort_post", 1'b0);
                    exp_q.delete();
                    return;
                end
                load = (k == busy_k && j == 0);
                if (load) din = 8'hFF;
                shift_en = (j == per - 1);
                step();
                load = 1'b0;
            end
            void'(exp_q.pop_front());
        end
        check_idle("done_cyc", 1'b1);
    endtask

    initial begin
        // reset with no clock activity
        #1 rst = 1'b0;
        #2 check_idle("reset", 1'b0);
        rst = 1'b1;
        #2 check_idle("reset_rel", 1'b0);
        clk_en = 1'b1;
        step();
        step();
        check_idle("idle", 1'b0);

        // single frame, continuous tick
        run_frame(8'hA5, 1, -1, -1, -1);
        step();
        check_idle("post_done", 1'b0);

        // gapped tick, one shift every 4th cycle
        run_frame(8'h3C, 4, -1, -1, -1);
        step();

        // busy load ignored, then a load in the done cycle
        run_frame(8'h5A, 1, 3, -1, -1);
        run_frame(8'h81, 1, -1, -1, -1);
        step();

        // reset mid-frame, then a clean frame
        run_frame(8'hA5, 1, -1, -1, 4);
        run_frame(8'h0F, 1, -1, -1, -1);
        step();

        // abort in idle beats load
        din   = 8'h77;
        load  = 1'b1;
        abort = 1'b1;
        step();
        load  = 1'b0;
        abort = 1'b0;
        check_idle("abort_idle", 1'b0);
        step();
        check_idle("abort_idle2", 1'b0);

        for (int i = 0; i < 4; i++) begin
            run_frame(W'($urandom_range(0, 255)), $urandom_range(1, 3), -1, -1, -1);
            repeat ($urandom_range(0, 2)) step();
        end
        step();

        // MSB-first instance: full frame and abort
        use_msb = 1'b1;
        #1;
        run_frame(8'hA5, 1, -1, -1, -1);
        step();
        run_frame(8'hA5, 1, -1, 2, -1);
        for (int i = 0; i < 3; i++) begin
            run_frame(W'($urandom_range(0, 255)), $urandom_range(1, 3), -1, -1, -1);
            repeat ($urandom_range(0, 2)) step();
        end

        // final report
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
